gpio_controller: RTL and testbench

Memory-mapped GPIO peripheral that sits directly downstream of the memory map decoder on its GPIO chip-select channel (window 0x1001_0024–0x1001_002B). It consumes the decoder's address, write data, strobes and GPIO select. It returns read data on the decoder's GPIO data-in channel. Inputs are synchronised, debounced and change-flagged; outputs are held in a writable register that drives board pins.

---
 rtl/gpio_controller_pkg.sv | 35 +++
 rtl/gpio_controller_debounce.sv | 71 +++++++
 rtl/gpio_controller.sv | 107 ++++++++++
 tb/tb_gpio_controller.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_controller_pkg.sv
// gpio_controller_pkg
// Shared constants for the memory-mapped GPIO peripheral: the decoder
// window it answers in, the word-offset codes decoded from AddrIn[3:2],
// the bit split of the IN_REG read word, and a helper that packs it.
package gpio_controller_pkg;

    // Address window served by the decoder's GPIO chip-select channel.
    localparam logic [31:0] GPIO_BASE  = 32'h1001_0024;
    localparam logic [31:0] GPIO_LIMIT = 32'h1001_002B;

    // Word offsets within the window (AddrIn[3:2]).
    typedef enum logic [1:0] {
        OFF_NONE_0 = 2'b00,
        OFF_IN     = 2'b01,
        OFF_OUT    = 2'b10,
        OFF_NONE_3 = 2'b11
    } gpio_off_e;

    // IN_REG field split: debounced levels low, change flags high.
    localparam int DEB_LSB = 0;
    localparam int DEB_MSB = 15;
    localparam int FLG_LSB = 16;
    localparam int FLG_MSB = 31;

    // Build the IN_REG read word from zero-extended flags and levels.
    function automatic logic [31:0] pack_in_reg(input logic [15:0] flags,
                                                input logic [15:0] deb);
        logic [31:0] word;
        word = 32'd0;
        word[FLG_MSB:FLG_LSB] = flags;
        word[DEB_MSB:DEB_LSB] = deb;
        return word;
    endfunction

endpackage

// File: rtl/gpio_controller_debounce.sv
// gpio_debounce
// Input conditioning for the GPIO pins: two-flop synchroniser, a free
// running prescaler that produces one sample tick every DEBOUNCE_CYCLES
// clocks, and a per-bit debouncer that accepts a new level only when two
// consecutive ticks observe it.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   pins_i        raw asynchronous pin levels
//   debounced_o   filtered pin levels
//   changed_o     per-bit pulse, high in the cycle whose edge changes debounced_o
module gpio_debounce
    import gpio_controller_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pins_i,
    output logic [WIDTH-1:0] debounced_o,
    output logic [WIDTH-1:0] changed_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] sync1_q, sync2_q, sample_q, sample_d, deb_q, deb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             tick_s;
    logic [WIDTH-1:0] agree_s;

    // Prescaler, sample capture and debounce next-state.
    always_comb begin
        tick_s   = (cnt_q == CNT_LAST);
        agree_s  = ~(sync2_q ^ sample_q);
        cnt_d    = cnt_q;
        sample_d = sample_q;
        deb_d    = deb_q;
        if (tick_s) begin
            cnt_d    = {CW{1'b0}};
            sample_d = sync2_q;
            // Only bits whose level matched at the previous tick may move.
            deb_d    = (deb_q & ~agree_s) | (sync2_q & agree_s);
        end else begin
            cnt_d    = cnt_q + CNT_ONE;
        end
    end

    // Synchroniser, prescaler, sample and debounced state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= {WIDTH{1'b0}};
            sync2_q  <= {WIDTH{1'b0}};
            sample_q <= {WIDTH{1'b0}};
            deb_q    <= {WIDTH{1'b0}};
            cnt_q    <= {CW{1'b0}};
        end else begin
            sync1_q  <= pins_i;
            sync2_q  <= sync1_q;
            sample_q <= sample_d;
            deb_q    <= deb_d;
            cnt_q    <= cnt_d;
        end
    end

    assign debounced_o = deb_q;
    // Combinational so the flag sets on the same edge the level changes.
    assign changed_o   = deb_d ^ deb_q;

endmodule

// File: rtl/gpio_controller.sv
// gpio_controller
// Memory-mapped GPIO peripheral behind the decoder's GPIO chip select.
// IN_REG  (offset 01, read-only): {change_flags, debounced}, read with
//          MemRead and without MemWrite clears the flags.
// OUT_REG (offset 10, read/write): drives gpio_out.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   Select              GPIO chip select from the decoder
//   MemRead, MemWrite   bus strobes
//   AddrIn              address, only [3:2] decoded
//   DataIn              write data
//   DataOut             combinational read data, 0 when not selected
//   gpio_in             asynchronous board inputs
//   gpio_out            registered board outputs
module gpio_controller
    import gpio_controller_pkg::*;
#(
    parameter int          WIDTH           = 16,
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter logic [15:0] OUT_RESET       = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Select,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [31:0]      AddrIn,
    input  logic [31:0]      DataIn,
    output logic [31:0]      DataOut,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out
);

    gpio_off_e        offset_s;
    logic             rd_clear_s, wr_en_s;
    logic [WIDTH-1:0] debounced_s, changed_s;
    logic [WIDTH-1:0] flags_q, flags_d, out_q, out_d;
    logic [15:0]      deb_ext_s, flg_ext_s, out_ext_s;
    logic             unused_s;

    gpio_debounce #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk         (clk),
        .rst         (rst),
        .pins_i      (gpio_in),
        .debounced_o (debounced_s),
        .changed_o   (changed_s)
    );

    assign offset_s   = gpio_off_e'(AddrIn[3:2]);
    // A combined read+write is treated as a write only.
    assign rd_clear_s = Select & MemRead & ~MemWrite & (offset_s == OFF_IN);
    assign wr_en_s    = Select & MemWrite & (offset_s == OFF_OUT);
    assign unused_s   = ^{AddrIn[31:4], AddrIn[1:0], DataIn[31:WIDTH]};

    // Flag and output-register next-state; a set beats a clear per bit.
    always_comb begin
        flags_d = flags_q;
        out_d   = out_q;
        if (rd_clear_s) begin
            flags_d = changed_s;
        end else begin
            flags_d = flags_q | changed_s;
        end
        if (wr_en_s) begin
            out_d = DataIn[WIDTH-1:0];
        end else begin
            out_d = out_q;
        end
    end

    // Flag and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= {WIDTH{1'b0}};
            out_q   <= OUT_RESET[WIDTH-1:0];
        end else begin
            flags_q <= flags_d;
            out_q   <= out_d;
        end
    end

    // Zero-extend narrow fields and mux the read word.
    always_comb begin
        deb_ext_s = 16'd0;
        flg_ext_s = 16'd0;
        out_ext_s = 16'd0;
        deb_ext_s[WIDTH-1:0] = debounced_s;
        flg_ext_s[WIDTH-1:0] = flags_q;
        out_ext_s[WIDTH-1:0] = out_q;
        DataOut = 32'd0;
        if (Select) begin
            case (offset_s)
                OFF_IN:  DataOut = pack_in_reg(flg_ext_s, deb_ext_s);
                OFF_OUT: DataOut = {16'd0, out_ext_s};
                default: DataOut = 32'd0;
            endcase
        end else begin
            DataOut = 32'd0;
        end
    end

    assign gpio_out = out_q;

endmodule

// File: tb/tb_gpio_controller.sv
module tb_gpio_controller;

    localparam int          WIDTH   = 16;
    localparam int          DEB     = 4;
    localparam logic [15:0] OUT_RST = 16'h00A5;
    localparam logic [31:0] A_IN    = 32'h1001_0024;
    localparam logic [31:0] A_OUT   = 32'h1001_0028;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel, mrd, mwr;
    logic [31:0] addr, din, dout;
    logic [15:0] pins, gout;

    gpio_controller #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEB),
        .OUT_RESET       (OUT_RST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Select   (sel),
        .MemRead  (mrd),
        .MemWrite (mwr),
        .AddrIn   (addr),
        .DataIn   (din),
        .DataOut  (dout),
        .gpio_in  (pins),
        .gpio_out (gout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pin history per clock edge since reset, plus the
    // architectural register contents.
    logic [15:0] hist[$];
    int          edge_n;
    logic [15:0] m_deb, m_flags, m_out;
    logic [31:0] dout_pre, exp_pre;

    typedef struct {
        string       name;
        logic        s, r, w;
        logic [31:0] a, d, exp_dout;
        logic [15:0] exp_out;
    } vec_t;
    vec_t vecs[12];

    function automatic vec_t mk(input string nm, input logic s, input logic r, input logic w,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] ed, input logic [15:0] eo);
        vec_t v;
        v.name = nm; v.s = s; v.r = r; v.w = w; v.a = a; v.d = d;
        v.exp_dout = ed; v.exp_out = eo;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pin level driven before edge k (k counted from 1 after reset).
    function automatic logic [15:0] pin_at(input int k);
        if (k >= 1 && k <= hist.size()) return hist[k-1];
        else return 16'd0;
    endfunction

    // Debounced bits that will change at the next edge: on every DEB-th
    // edge the level seen two edges earlier is accepted where it matches
    // the level seen one tick period before that.
    function automatic logic [15:0] model_next_chg();
        logic [15:0] cand, prev, agree, nd;
        if (((edge_n + 1) % DEB) != 0) return 16'd0;
        cand  = pin_at(edge_n - 1);
        prev  = pin_at(edge_n - 1 - DEB);
        agree = ~(cand ^ prev);
        nd    = (m_deb & ~agree) | (cand & agree);
        return nd ^ m_deb;
    endfunction

    function automatic logic [31:0] model_dout(input logic s, input logic [31:0] a);
        if (!s) return 32'd0;
        if (a[3:2] == 2'b01) return {m_flags, m_deb};
        if (a[3:2] == 2'b10) return {16'd0, m_out};
        return 32'd0;
    endfunction

    task automatic model_reset();
        hist.delete();
        edge_n  = 0;
        m_deb   = 16'd0;
        m_flags = 16'd0;
        m_out   = OUT_RST;
    endtask

    task automatic model_edge(input logic s, input logic r, input logic w,
                              input logic [31:0] a, input logic [31:0] d, input logic [15:0] p);
        logic [15:0] chg;
        chg = model_next_chg();
        hist.push_back(p);
        edge_n++;
        m_deb = m_deb ^ chg;
        if (s && r && !w && a[3:2] == 2'b01) m_flags = 16'd0;
        m_flags = m_flags | chg;
        if (s && w && a[3:2] == 2'b10) m_out = d[15:0];
    endtask

    // One bus cycle, entered and left at a falling edge.
    task automatic step(input logic s, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input logic [15:0] p);
        sel = s; mrd = r; mwr = w; addr = a; din = d; pins = p;
        #1;
        dout_pre = dout;
        exp_pre  = model_dout(s, a);
        check("model_dout", dout_pre, exp_pre);
        @(posedge clk);
        model_edge(s, r, w, a, d, p);
        @(negedge clk);
        check("model_gpio_out", {16'd0, gout}, {16'd0, m_out});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          found;
        logic [15:0] rp;
        logic [1:0]  off;

        rst = 1'b1; sel = 1'b0; mrd = 1'b0; mwr = 1'b0;
        addr = 32'd0; din = 32'd0; pins = 16'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_gpio_out", {16'd0, gout}, 32'h0000_00A5);
        check("reset_dout_unsel", dout, 32'd0);
        rst = 1'b0;

        // Register map and write behaviour, pins held low.
        vecs[0]  = mk("idle_sel0",   1'b0, 1'b1, 1'b0, A_IN,          32'd0,         32'd0,         16'h00A5);
        vecs[1]  = mk("in_reset",    1'b1, 1'b1, 1'b0, A_IN,          32'd0,         32'd0,         16'h00A5);
        vecs[2]  = mk("out_reset",   1'b1, 1'b1, 1'b0, A_OUT,         32'd0,         32'h0000_00A5, 16'h00A5);
        vecs[3]  = mk("write_out",   1'b1, 1'b0, 1'b1, A_OUT,         32'hF1FA_F1FA, 32'h0000_00A5, 16'hF1FA);
        vecs[4]  = mk("readback",    1'b1, 1'b1, 1'b0, A_OUT,         32'd0,         32'h0000_F1FA, 16'hF1FA);
        vecs[5]  = mk("write_sel0",  1'b0, 1'b0, 1'b1, A_OUT,         32'h1234_5678, 32'd0,         16'hF1FA);
        vecs[6]  = mk("write_off00", 1'b1, 1'b0, 1'b1, 32'h1001_0020, 32'h1111_1111, 32'd0,         16'hF1FA);
        vecs[7]  = mk("write_off11", 1'b1, 1'b0, 1'b1, 32'h1001_002C, 32'h2222_2222, 32'd0,         16'hF1FA);
        vecs[8]  = mk("read_off11",  1'b1, 1'b1, 1'b0, 32'h1001_002C, 32'd0,         32'd0,         16'hF1FA);
        vecs[9]  = mk("write_in",    1'b1, 1'b0, 1'b1, A_IN,          32'h5555_5555, 32'd0,         16'hF1FA);
        vecs[10] = mk("rdwr_out",    1'b1, 1'b1, 1'b1, A_OUT,         32'h0000_0A0A, 32'h0000_F1FA, 16'h0A0A);
        vecs[11] = mk("readback2",   1'b1, 1'b1, 1'b0, A_OUT,         32'd0,         32'h0000_0A0A, 16'h0A0A);
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].s, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, 16'd0);
            check({vecs[i].name, "_dout"}, dout_pre, vecs[i].exp_dout);
            check({vecs[i].name, "_out"}, {16'd0, gout}, {16'd0, vecs[i].exp_out});
        end

        // Stable input on bit 0 must be accepted within 2 + 2*DEB edges.
        found = 0;
        for (int i = 0; i < 2 + 2 * DEB; i++) begin
            step(1'b1, 1'b0, 1'b0, A_IN, 32'd0, 16'h0001);
            if (dout[0] === 1'b1) begin
                found = 1;
                break;
            end
        end
        check("debounce_latency", found, 1);
        check("debounce_in_reg", dout, 32'h0001_0001);

        // Two-cycle glitch on bit 1 must never reach debounced or flags.
        step(1'b1, 1'b0, 1'b0, A_IN, 32'd0, 16'h0003);
        step(1'b1, 1'b0, 1'b0, A_IN, 32'd0, 16'h0003);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, A_IN, 32'd0, 16'h0001);
        check("glitch_rejected", dout & 32'h0002_0002, 32'd0);

        // Read-clear returns pre-clear flags, then flags are gone.
        step(1'b1, 1'b1, 1'b0, A_IN, 32'd0, 16'h0001);
        check("readclear_first", dout_pre, 32'h0001_0001);
        step(1'b1, 1'b1, 1'b0, A_IN, 32'd0, 16'h0001);
        check("readclear_second", dout_pre, 32'h0000_0001);

        // Falling bit 0 sets its flag; read+write at IN keeps it.
        found = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 1'b0, A_IN, 32'd0, 16'h0000);
            if (dout[0] === 1'b0) begin
                found = 1;
                break;
            end
        end
        check("fall_seen", found, 1);
        step(1'b1, 1'b1, 1'b1, A_IN, 32'hFFFF_FFFF, 16'h0000);
        check("rdwr_in_dout", dout_pre, 32'h0001_0000);
        check("rdwr_in_no_write", {16'd0, gout}, 32'h0000_0A0A);
        step(1'b1, 1'b1, 1'b0, A_IN, 32'd0, 16'h0000);
        check("rdwr_in_flags_kept", dout_pre, 32'h0001_0000);

        // Set/clear collision: bit 2 changes on the read-clear edge.
        found = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 1'b0, A_IN, 32'd0, 16'h0001);
            if (dout[0] === 1'b1) begin
                found = 1;
                break;
            end
        end
        check("rise_seen", found, 1);
        pins = 16'h0005;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (model_next_chg() == 16'h0004) begin
                found = 1;
                break;
            end
            step(1'b1, 1'b0, 1'b0, A_IN, 32'd0, 16'h0005);
        end
        check("collision_aligned", found, 1);
        step(1'b1, 1'b1, 1'b0, A_IN, 32'd0, 16'h0005);
        check("collision_pre", dout_pre, 32'h0001_0001);
        check("collision_post", dout, 32'h0004_0005);

        // Randomised traffic against the model.
        rp = 16'h0005;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) rp = rp ^ (16'd1 << $urandom_range(0, 15));
            off = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                 32'h1001_0020 | {28'd0, off, 2'b00}, $urandom, rp);
        end

        // Asynchronous reset between edges with a write pending.
        step(1'b1, 1'b0, 1'b1, A_OUT, 32'h0000_1234, 16'd0);
        check("pre_reset_write", {16'd0, gout}, 32'h0000_1234);
        sel = 1'b1; mwr = 1'b1; mrd = 1'b0; addr = A_OUT; din = 32'h0000_3C3C; pins = 16'd0;
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_immediate", {16'd0, gout}, 32'h0000_00A5);
        @(posedge clk);
        @(negedge clk);
        check("reset_held_no_write", {16'd0, gout}, 32'h0000_00A5);
        model_reset();
        sel = 1'b0; mwr = 1'b0;
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, A_OUT, 32'd0, 16'd0);
        check("no_pending_write", {16'd0, gout}, 32'h0000_00A5);
        step(1'b1, 1'b1, 1'b0, A_OUT, 32'd0, 16'd0);
        check("post_reset_out_reg", dout_pre, 32'h0000_00A5);
        step(1'b1, 1'b1, 1'b0, A_IN, 32'd0, 16'd0);
        check("post_reset_in_reg", dout_pre, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
